// File: rtl/mem_pkg.sv
// Shared definitions for the memory access stage: size encodings, FSM states
// and the wait-counter width helper.
package mem_pkg;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;
    localparam logic [1:0] SZ_RSVD = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ACCESS,
        ST_DONE,
        ST_ABORT
    } mau_state_e;

    // Counter runs 0..timeout-1 while the request is outstanding.
    function automatic int cnt_width(input int timeout);
        return (timeout <= 2) ? 1 : $clog2(timeout);
    endfunction

endpackage

// File: rtl/load_align.sv
// Combinational load steering: byte/half lane select with sign or zero
// extension, and right-rotation of unaligned words.
module load_align
    import mem_pkg::*;
(
    input  logic [31:0] rdata,
    input  logic [1:0]  addr,
    input  logic [1:0]  size,
    input  logic        sgn,
    output logic [31:0] result
);

    logic [7:0]  byte_v;
    logic [15:0] half_v;
    logic [63:0] rot;

    always_comb begin
        byte_v = rdata[{addr, 3'b000} +: 8];
        half_v = rdata[{addr[1], 4'b0000} +: 16];
        rot    = {rdata, rdata} >> {addr, 3'b000};
        case (size)
            SZ_BYTE: result = {{24{sgn & byte_v[7]}}, byte_v};
            SZ_HALF: result = {{16{sgn & half_v[15]}}, half_v};
            default: result = rot[31:0];
        endcase
    end

endmodule

// File: rtl/mem_access_unit.sv
// Memory access stage: owns MAR/MWDR/MRDR and runs one RAM load or store per
// mem_start over a registered req/ack handshake with a bounded wait.
module mem_access_unit
    import mem_pkg::*;
#(
    parameter int TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] c_bus_in,
    input  logic [31:0] b_bus_in,
    input  logic        ld_mar,
    input  logic        ld_mwdr,
    input  logic        mem_start,
    input  logic        mem_rw,
    input  logic [1:0]  mem_size,
    input  logic        mem_signed,
    output logic [31:0] mrdr,
    output logic        mem_busy,
    output logic        mem_done,
    output logic        mem_abort,
    output logic        ram_req,
    output logic        ram_we,
    output logic [3:0]  ram_be,
    output logic [31:0] ram_addr,
    output logic [31:0] ram_wdata,
    input  logic [31:0] ram_rdata,
    input  logic        ram_ack
);

    localparam int CW = cnt_width(TIMEOUT);

    mau_state_e      state, state_nxt;
    logic [31:0]     mar, mwdr;
    logic            rw_q, sgn_q;
    logic [1:0]      size_q;
    logic [CW-1:0]   cnt;
    logic [31:0]     eff_addr;
    logic            illegal;
    logic            idle;
    logic [31:0]     ld_result;

    assign idle     = (state == ST_IDLE);
    assign eff_addr = ld_mar ? c_bus_in : mar;
    assign illegal  = (mem_size == SZ_RSVD) || ((mem_size == SZ_HALF) && eff_addr[0]);

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:   if (mem_start) state_nxt = illegal ? ST_ABORT : ST_ACCESS;
            // ack beats an expiring counter
            ST_ACCESS: if (ram_ack) state_nxt = ST_DONE;
                       else if (cnt == CW'(TIMEOUT - 1)) state_nxt = ST_ABORT;
            ST_DONE:   state_nxt = ST_IDLE;
            ST_ABORT:  state_nxt = ST_IDLE;
            default:   state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= ST_IDLE;
            mar     <= '0;
            mwdr    <= '0;
            mrdr    <= '0;
            rw_q    <= 1'b0;
            sgn_q   <= 1'b0;
            size_q  <= SZ_BYTE;
            cnt     <= '0;
            ram_req <= 1'b0;
        end else begin
            state   <= state_nxt;
            ram_req <= (state_nxt == ST_ACCESS);
            if (idle) begin
                // MAR doubles as the latched effective address for the access
                if (ld_mar)  mar  <= c_bus_in;
                if (ld_mwdr) mwdr <= b_bus_in;
                if (mem_start) begin
                    rw_q   <= mem_rw;
                    size_q <= mem_size;
                    sgn_q  <= mem_signed;
                    cnt    <= '0;
                end
            end
            if (state == ST_ACCESS) begin
                cnt <= cnt + CW'(1);
                if (ram_ack && !rw_q) mrdr <= ld_result;
            end
        end
    end

    load_align u_load_align (
        .rdata  (ram_rdata),
        .addr   (mar[1:0]),
        .size   (size_q),
        .sgn    (sgn_q),
        .result (ld_result)
    );

    // Bus-facing RAM signals are held at zero outside the request window.
    always_comb begin
        ram_addr  = '0;
        ram_we    = 1'b0;
        ram_be    = 4'b0000;
        ram_wdata = '0;
        if (ram_req) begin
            ram_addr = {mar[31:2], 2'b00};
            ram_we   = rw_q;
            case (size_q)
                SZ_BYTE: begin
                    ram_wdata = {4{mwdr[7:0]}};
                    ram_be    = 4'b0001 << mar[1:0];
                end
                SZ_HALF: begin
                    ram_wdata = {2{mwdr[15:0]}};
                    ram_be    = mar[1] ? 4'b1100 : 4'b0011;
                end
                default: begin
                    ram_wdata = mwdr;
                    ram_be    = 4'b1111;
                end
            endcase
        end
    end

    assign mem_busy  = !idle;
    assign mem_done  = (state == ST_DONE);
    assign mem_abort = (state == ST_ABORT);

endmodule

// File: tb/tb_mem_access_unit.sv
// Bench for mem_access_unit: directed vector table, randomized accesses against
// an arithmetic reference model, busy-input masking and mid-access reset.
module tb_mem_access_unit;
    import mem_pkg::*;

    localparam int TO = 16;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] c_bus_in, b_bus_in, ram_rdata;
    logic        ld_mar, ld_mwdr, mem_start, mem_rw, mem_signed, ram_ack;
    logic [1:0]  mem_size;
    logic [31:0] mrdr, ram_addr, ram_wdata;
    logic        mem_busy, mem_done, mem_abort, ram_req, ram_we;
    logic [3:0]  ram_be;

    int n_chk = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    mem_access_unit #(.TIMEOUT(TO)) dut (
        .clk(clk), .rst_n(rst_n), .c_bus_in(c_bus_in), .b_bus_in(b_bus_in),
        .ld_mar(ld_mar), .ld_mwdr(ld_mwdr), .mem_start(mem_start), .mem_rw(mem_rw),
        .mem_size(mem_size), .mem_signed(mem_signed), .mrdr(mrdr), .mem_busy(mem_busy),
        .mem_done(mem_done), .mem_abort(mem_abort), .ram_req(ram_req), .ram_we(ram_we),
        .ram_be(ram_be), .ram_addr(ram_addr), .ram_wdata(ram_wdata),
        .ram_rdata(ram_rdata), .ram_ack(ram_ack)
    );

    typedef struct {
        logic        rw;
        logic [1:0]  size;
        logic        sgn;
        logic [31:0] addr;
        logic        ldmar;
        logic [31:0] wdata;
        logic [31:0] rdata;
        int          delay;      // req cycles before ack; 0 = never ack
        logic        exp_done;
        logic [31:0] exp_mrdr;
        logic [31:0] exp_wdata;
        logic [3:0]  exp_be;
    } vec_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] ld_model(input logic [31:0] w, input logic [1:0] a,
                                             input logic [1:0] sz, input logic sg);
        logic [63:0] d;
        logic [31:0] v;
        case (sz)
            2'd0: begin
                v = (w >> (int'(a) * 8)) & 32'hFF;
                if (sg && v[7]) v = v | 32'hFFFF_FF00;
            end
            2'd1: begin
                v = (w >> (int'(a[1]) * 16)) & 32'hFFFF;
                if (sg && v[15]) v = v | 32'hFFFF_0000;
            end
            default: begin
                d = {w, w} >> (int'(a) * 8);
                v = d[31:0];
            end
        endcase
        return v;
    endfunction

    function automatic logic [31:0] st_data_model(input logic [31:0] d, input logic [1:0] sz);
        if (sz == 2'd0) return d[7:0] * 32'h0101_0101;
        if (sz == 2'd1) return d[15:0] * 32'h0001_0001;
        return d;
    endfunction

    function automatic logic [3:0] be_model(input logic [1:0] a, input logic [1:0] sz);
        if (sz == 2'd0) return 4'(1 << int'(a));
        if (sz == 2'd1) return a[1] ? 4'b1100 : 4'b0011;
        return 4'b1111;
    endfunction

    function automatic vec_t mk(input logic rw, input logic [1:0] sz, input logic sg,
                                input logic [31:0] addr, input logic ldm, input logic [31:0] wd,
                                input logic [31:0] rd, input int dly, input logic done,
                                input logic [31:0] em, input logic [31:0] ew, input logic [3:0] eb);
        vec_t v;
        v.rw = rw; v.size = sz; v.sgn = sg; v.addr = addr; v.ldmar = ldm;
        v.wdata = wd; v.rdata = rd; v.delay = dly; v.exp_done = done;
        v.exp_mrdr = em; v.exp_wdata = ew; v.exp_be = eb;
        return v;
    endfunction

    // Starts at a negedge with the DUT idle; returns at a negedge with it idle.
    task automatic do_access(input vec_t v, input logic poke,
                             output logic got_done, output logic got_abort,
                             output int lat, output int reqs,
                             output logic [31:0] a_addr, output logic [31:0] a_wdata,
                             output logic [3:0] a_be, output logic a_we, output logic stable);
        got_done = 1'b0; got_abort = 1'b0; lat = -1; reqs = 0; stable = 1'b1;
        a_addr = '0; a_wdata = '0; a_be = '0; a_we = 1'b0;
        if (!v.ldmar) begin
            c_bus_in = v.addr; ld_mar = 1'b1;
            @(negedge clk);
            c_bus_in = $urandom;
        end else begin
            c_bus_in = v.addr;
        end
        ld_mar = v.ldmar;
        b_bus_in = v.wdata; ld_mwdr = 1'b1; mem_start = 1'b1;
        mem_rw = v.rw; mem_size = v.size; mem_signed = v.sgn;
        @(negedge clk);
        ld_mar = 1'b0; ld_mwdr = 1'b0; mem_start = 1'b0;
        c_bus_in = $urandom; b_bus_in = $urandom;
        mem_rw = 1'($urandom); mem_size = 2'($urandom); mem_signed = 1'($urandom);
        for (int cyc = 1; cyc <= TO + 6; cyc++) begin
            if (ram_req) begin
                if (reqs == 0) begin
                    a_addr = ram_addr; a_wdata = ram_wdata; a_be = ram_be; a_we = ram_we;
                end else if (a_addr !== ram_addr || a_wdata !== ram_wdata ||
                             a_be !== ram_be || a_we !== ram_we) begin
                    stable = 1'b0;
                end
                reqs++;
                ram_ack = (reqs == v.delay);
                ram_rdata = ram_ack ? v.rdata : $urandom;
                if (poke) begin
                    ld_mar = 1'b1; c_bus_in = 32'hFFFF_FFF0;
                    ld_mwdr = 1'b1; b_bus_in = $urandom; mem_start = 1'b1;
                end
            end else begin
                ram_ack = 1'b0; ld_mar = 1'b0; ld_mwdr = 1'b0; mem_start = 1'b0;
            end
            if (mem_done || mem_abort) begin
                got_done = mem_done; got_abort = mem_abort; lat = cyc;
                break;
            end
            @(negedge clk);
        end
        ram_ack = 1'b0; ld_mar = 1'b0; ld_mwdr = 1'b0; mem_start = 1'b0;
        @(negedge clk);
    endtask

    task automatic run_check(input string tag, input vec_t v, input logic poke);
        logic gd, ga, a_we, stable, bad;
        int lat, reqs, exp_lat, exp_reqs;
        logic [31:0] a_addr, a_wdata;
        logic [3:0] a_be;
        do_access(v, poke, gd, ga, lat, reqs, a_addr, a_wdata, a_be, a_we, stable);
        bad = (v.size == 2'd3) || (v.size == 2'd1 && v.addr[0]);
        exp_lat  = bad ? 1 : (v.delay == 0 ? TO + 1 : v.delay + 1);
        exp_reqs = bad ? 0 : (v.delay == 0 ? TO : v.delay);
        chk({tag, " outcome"}, {30'b0, gd, ga}, v.exp_done ? 32'd2 : 32'd1);
        chk({tag, " latency"}, 32'(lat), 32'(exp_lat));
        chk({tag, " req_cycles"}, 32'(reqs), 32'(exp_reqs));
        chk({tag, " mrdr"}, mrdr, v.exp_mrdr);
        chk({tag, " busy_after"}, {31'b0, mem_busy}, 32'd0);
        if (!bad) begin
            chk({tag, " ram_addr"}, a_addr, v.addr & 32'hFFFF_FFFC);
            chk({tag, " ram_we"}, {31'b0, a_we}, {31'b0, v.rw});
            chk({tag, " stable"}, {31'b0, stable}, 32'd1);
            if (v.rw || v.size == 2'd2) chk({tag, " ram_be"}, {28'b0, a_be}, {28'b0, v.exp_be});
            if (v.rw) chk({tag, " ram_wdata"}, a_wdata, v.exp_wdata);
        end
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t tbl[$];
        vec_t v;
        logic [31:0] m_mrdr;
        logic bad;

        rst_n = 1'b0; c_bus_in = '0; b_bus_in = '0; ld_mar = 0; ld_mwdr = 0;
        mem_start = 0; mem_rw = 0; mem_size = 0; mem_signed = 0; ram_rdata = '0; ram_ack = 0;
        repeat (2) @(negedge clk);
        chk("reset outputs", {28'b0, ram_req, mem_busy, mem_done, mem_abort}, 32'd0);
        chk("reset mrdr", mrdr, 32'd0);
        chk("reset ram_bus", ram_addr | ram_wdata | {28'b0, ram_be} | {31'b0, ram_we}, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        //            rw sz    sg addr        ldm wdata         rdata         dly done mrdr          wdata         be
        tbl.push_back(mk(0, 2'd2, 0, 32'h103, 0, 32'h0,         32'hAABBCCDD, 1,  1, 32'hBBCCDDAA, 32'h0,         4'hF));
        tbl.push_back(mk(0, 2'd0, 1, 32'h202, 0, 32'h0,         32'h0080FF00, 3,  1, 32'hFFFFFF80, 32'h0,         4'h0));
        tbl.push_back(mk(0, 2'd0, 0, 32'h202, 0, 32'h0,         32'h0080FF00, 2,  1, 32'h00000080, 32'h0,         4'h0));
        tbl.push_back(mk(1, 2'd1, 0, 32'h302, 0, 32'h1234ABCD, 32'h0,         2,  1, 32'h00000080, 32'hABCDABCD, 4'hC));
        tbl.push_back(mk(0, 2'd1, 0, 32'h301, 0, 32'h0,         32'h0,         1,  0, 32'h00000080, 32'h0,         4'h0));
        tbl.push_back(mk(0, 2'd3, 0, 32'h300, 0, 32'h0,         32'h0,         1,  0, 32'h00000080, 32'h0,         4'h0));
        tbl.push_back(mk(0, 2'd2, 0, 32'h0,   0, 32'h0,         32'h12345678, 0,  0, 32'h00000080, 32'h0,         4'hF));
        tbl.push_back(mk(0, 2'd2, 0, 32'h0,   0, 32'h0,         32'h11223344, TO, 1, 32'h11223344, 32'h0,         4'hF));
        tbl.push_back(mk(0, 2'd2, 0, 32'h40,  1, 32'h0,         32'hCAFEF00D, 1,  1, 32'hCAFEF00D, 32'h0,         4'hF));
        tbl.push_back(mk(1, 2'd0, 0, 32'h101, 0, 32'h00000055, 32'h0,         4,  1, 32'hCAFEF00D, 32'h55555555, 4'h2));
        tbl.push_back(mk(0, 2'd1, 1, 32'h102, 0, 32'h0,         32'h80017FFF, 2,  1, 32'hFFFF8001, 32'h0,         4'h0));
        tbl.push_back(mk(0, 2'd1, 0, 32'h100, 0, 32'h0,         32'h80017FFF, 1,  1, 32'h00007FFF, 32'h0,         4'h0));
        tbl.push_back(mk(1, 2'd2, 0, 32'h200, 0, 32'hDEADBEEF, 32'h0,         1,  1, 32'h00007FFF, 32'hDEADBEEF, 4'hF));
        foreach (tbl[i]) run_check($sformatf("vec%0d", i), tbl[i], 1'b0);
        m_mrdr = 32'h00007FFF;

        for (int n = 0; n < 40; n++) begin
            v.rw = 1'($urandom); v.size = 2'($urandom_range(0, 3)); v.sgn = 1'($urandom);
            v.addr = $urandom; v.ldmar = 1'($urandom); v.wdata = $urandom; v.rdata = $urandom;
            v.delay = ($urandom_range(0, 7) == 0) ? 0 : int'($urandom_range(1, TO));
            bad = (v.size == 2'd3) || (v.size == 2'd1 && v.addr[0]);
            v.exp_done = !bad && v.delay != 0;
            if (v.exp_done && !v.rw) m_mrdr = ld_model(v.rdata, v.addr[1:0], v.size, v.sgn);
            v.exp_mrdr = m_mrdr;
            v.exp_wdata = st_data_model(v.wdata, v.size);
            v.exp_be = be_model(v.addr[1:0], v.size);
            run_check($sformatf("rnd%0d", n), v, 1'b0);
        end

        // bus inputs toggled while busy must not disturb or restart the access
        v = mk(0, 2'd2, 0, 32'h208, 0, 32'h0, 32'h01020304, 4, 1, 32'h01020304, 32'h0, 4'hF);
        run_check("busy_ignore", v, 1'b1);

        // asynchronous reset in the middle of a request
        c_bus_in = 32'h500; ld_mar = 1'b1; mem_start = 1'b1; mem_rw = 1'b0; mem_size = 2'd2;
        @(negedge clk);
        ld_mar = 1'b0; mem_start = 1'b0;
        @(negedge clk);
        chk("midreset req_before", {31'b0, ram_req}, 32'd1);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("midreset outputs", {28'b0, ram_req, mem_busy, mem_done, mem_abort}, 32'd0);
        chk("midreset ram_bus", ram_addr | {28'b0, ram_be}, 32'd0);
        chk("midreset mrdr", mrdr, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("after reset no pulse", {30'b0, mem_done, mem_abort}, 32'd0);
        v = mk(0, 2'd0, 0, 32'h003, 0, 32'h0, 32'h9A000000, 1, 1, 32'h0000009A, 32'h0, 4'h0);
        run_check("post_reset", v, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/mem_access_unit.md
# mem_access_unit

Multi-cycle memory access stage between the datapath buses and `basic_ram`. It owns the MAR, MWDR and MRDR registers and sequences one load or store per request from `state_machine` through a req/ack handshake with the RAM. It performs ARMv4 byte, halfword and word lane steering, including sign or zero extension and unaligned-word rotation. MRDR drives the bus through an external tri-state buffer.

## Interface
Parameters:
- `TIMEOUT`, default 16: maximum cycles `ram_req` is held without `ram_ack` before the access aborts. Must be ≥2.

Ports:
- `clk`  in  1  single clock; all state changes on the rising edge.
- `rst_n`  in  1  asynchronous active-low reset.
- `c_bus_in`  in  32  address source for MAR.
- `b_bus_in`  in  32  store-data source for MWDR.
- `ld_mar`  in  1  load MAR from `c_bus_in`.
- `ld_mwdr`  in  1  load MWDR from `b_bus_in`.
- `mem_start`  in  1  begin an access.
- `mem_rw`  in  1  1 = store, 0 = load.
- `mem_size`  in  2  00 = byte, 01 = half, 10 = word, 11 = reserved.
- `mem_signed`  in  1  sign-extend byte/half loads.
- `mrdr`  out  32  load result register.
- `mem_busy`  out  1  access in flight.
- `mem_done`  out  1  one-cycle pulse on successful completion.
- `mem_abort`  out  1  one-cycle pulse on misalignment, reserved size or timeout.
- `ram_req`  out  1  RAM request, registered.
- `ram_we`  out  1  RAM write enable.
- `ram_be`  out  4  byte enables; bit n corresponds to `data[8n+7:8n]`.
- `ram_addr`  out  32  word address; bits [1:0] are always 0.
- `ram_wdata`  out  32  lane-replicated store data.
- `ram_rdata`  in  32  read data, valid when `ram_ack` = 1.
- `ram_ack`  in  1  completion; sampled while `ram_req` = 1.

## Operation
- FSM states: IDLE, ACCESS, DONE, ABORT.
- IDLE
  - On `mem_start`, latch `rw`, `size`, `signed` and the effective address.
  - The effective address is `c_bus_in` if `ld_mar` is also high that cycle; otherwise it is MAR.
  - If the request is illegal, go to ABORT. Illegal means `size`=11, or `size`=half with addr[0]=1.
  - Otherwise go to ACCESS.
- ACCESS
  - `ram_req`=1.
  - On `ram_ack`:
    - For a load, write the steered `ram_rdata` into MRDR.
    - Go to DONE.
  - If the wait counter reaches `TIMEOUT` with no ack, drop `ram_req` and go to ABORT.
- DONE and ABORT: each lasts exactly one cycle, pulses its output, then returns to IDLE.
- `mem_busy` = 1 in ACCESS, DONE and ABORT.
- While `mem_busy` = 1, `ld_mar`, `ld_mwdr` and `mem_start` are ignored.
- Store steering (`ram_wdata` / `ram_be`):
  - byte: the byte is replicated to all four lanes; `be` = 1 << addr[1:0].
  - half: the halfword is replicated to both halves; `be` = 0011 if addr[1]=0, 1100 if addr[1]=1.
  - word: data unchanged; `be` = 1111.
- Load steering:
  - byte: lane addr[1:0].
  - half: lane addr[1].
  - Byte and half results are zero- or sign-extended per `mem_signed`.
  - word: `ram_rdata` rotated right by 8×addr[1:0] (ARMv4 unaligned LDR).
- Stores leave MRDR unchanged. Aborts leave MRDR unchanged.

## Timing
- Reset values: `mrdr`, MAR, MWDR = 0; all outputs = 0; state = IDLE.
- Reset is asynchronous. If asserted mid-access, `ram_req` falls immediately and no pulse is issued.
- `mem_start` at edge t: `ram_req` = 1 from t+1.
- `ram_ack` sampled high at edge t+k (k ≥ 1): `mem_done` = 1 and MRDR is valid during cycle t+k+1.
- Minimum start-to-done latency is 2 cycles.
- Illegal request: `mem_abort` pulses in cycle t+1; `ram_req` is never asserted.
- Timeout: `ram_req` stays high for exactly `TIMEOUT` cycles, then falls; `mem_abort` pulses in the following cycle.
- If `ram_ack` arrives in the same cycle the counter expires, ack wins and the access completes with `mem_done`.
- `ram_addr`, `ram_we`, `ram_be` and `ram_wdata` are stable for the entire time `ram_req` is high.

## Structure
- Shared package `mem_pkg`:
  - size encodings `SZ_BYTE`, `SZ_HALF`, `SZ_WORD`;
  - FSM state enum;
  - timeout counter width derived from `TIMEOUT`.
- Sub-module `load_align`: purely combinational. Inputs are `rdata`, addr[1:0], `size` and `signed`; output is the 32-bit steered result.
- Store steering stays inline.

## Test plan
- Word load with MAR=0x103 and RAM word 0xAABBCCDD → `ram_addr`=0x100, `be`=1111, `mrdr`=0xBBCCDDAA, `mem_done` 2 cycles after start when ack is immediate.
- Signed byte load at 0x202 with word 0x0080FF00 → `mrdr`=0xFFFFFF80; the unsigned variant gives 0x00000080.
- Half store of 0x1234_ABCD to 0x302 → `ram_wdata`=0xABCDABCD, `be`=1100, `we`=1; `mrdr` unchanged.
- Half load at 0x301 → `mem_abort` at t+1, no `ram_req`; `mem_size`=11 → same response.
- `ram_ack` withheld with `TIMEOUT`=16 → `ram_req` high for 16 cycles, then abort pulse. Ack on cycle 16 → `mem_done` instead.
- `ld_mar`+`mem_start` in the same cycle with `c_bus_in`=0x40 → `ram_addr`=0x40. Reset asserted mid-ACCESS → all outputs 0 asynchronously, state IDLE.
